dm_responder: RTL and testbench

//  Data-memory responder. It is the memory-side end of the controller's DMRead/DMWrite strobe interface.
//  It holds a 16-bit word-addressed RAM, inserts a programmable number of wait states, and returns a
//  one-cycle DMReady handshake so the multi-cycle controller can stall in its memory states.
//  Out-of-range or conflicting requests complete with an error flag instead of hanging the controller.

---
 rtl/dm_responder.sv | 126 ++++++++++++
 tb/tb_dm_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// dm_responder: memory-side end of the controller's DMRead/DMWrite strobe
// interface. Holds a 16-bit word-addressed RAM, waits WAIT_CYCLES after
// capturing a request, then returns a one-cycle DMReady pulse. Out-of-range
// addresses or simultaneous read+write complete with DMErr instead of hanging.
//
// Ports:
//   Clk        clock, rising edge
//   Reset      synchronous, active-low reset
//   DMRead     read request (level, held until DMReady)
//   DMWrite    write request (level, held until DMReady)
//   Addr       16-bit word address, sampled at capture
//   WriteData  16-bit write data, sampled at capture
//   ReadData   last successful read result, held until the next one
//   DMReady    one-cycle completion pulse (registered)
//   DMErr      rejection flag, high together with DMReady (registered)
//
// state | meaning
// IDLE  | waiting for a strobe; capture request on the edge it is seen
// WAIT  | counting down wait states; access on the edge where count is 1
// RESP  | DMReady (and maybe DMErr) high for this single cycle
module dm_responder #(
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        DMRead,
  input  logic        DMWrite,
  input  logic [15:0] Addr,
  input  logic [15:0] WriteData,
  output logic [15:0] ReadData,
  output logic        DMReady,
  output logic        DMErr
);

  localparam logic [16:0] DEPTH   = 17'(1) << ADDR_BITS;
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                 state, state_nxt;
  logic [3:0]             cnt;
  logic                   op_write, op_err;
  logic [ADDR_BITS-1:0]   cap_addr;
  logic [15:0]            cap_data;
  logic                   capture, access;
  logic                   req_err;
  logic                   acc_write, acc_err;
  logic [ADDR_BITS-1:0]   acc_addr;
  logic [15:0]            acc_data;
  logic [15:0]            mem [2**ADDR_BITS];

  assign req_err = (DMRead & DMWrite) | ({1'b0, Addr} >= DEPTH);

  // With zero wait states the access happens on the capture edge itself, so
  // the operands come straight from the ports instead of the capture regs.
  assign acc_write = capture ? (DMWrite & ~DMRead)        : op_write;
  assign acc_err   = capture ? req_err                     : op_err;
  assign acc_addr  = capture ? Addr[ADDR_BITS-1:0]         : cap_addr;
  assign acc_data  = capture ? WriteData                   : cap_data;

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    access    = 1'b0;
    case (state)
      IDLE: begin
        if (DMRead | DMWrite) begin
          capture = 1'b1;
          if (WAIT_CYCLES == 0) begin
            access    = 1'b1;
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd1) begin
          access    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      DMReady  <= 1'b0;
      DMErr    <= 1'b0;
      ReadData <= 16'h0000;
      op_write <= 1'b0;
      op_err   <= 1'b0;
      cap_addr <= '0;
      cap_data <= 16'h0000;
    end else begin
      state   <= state_nxt;
      DMReady <= access;
      DMErr   <= access & acc_err;
      if (capture) begin
        cnt      <= WAIT_LD;
        op_write <= DMWrite & ~DMRead;
        op_err   <= req_err;
        cap_addr <= Addr[ADDR_BITS-1:0];
        cap_data <= WriteData;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (access && !acc_write && !acc_err) begin
        ReadData <= mem[acc_addr];
      end
    end
  end

  // RAM is not reset; a write is only committed outside reset.
  always_ff @(posedge Clk) begin
    if (Reset && access && acc_write && !acc_err) begin
      mem[acc_addr] <= acc_data;
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// tb_dm_responder: self-checking bench for dm_responder. Instance dut_a uses
// two wait states, dut_b uses none. Inputs are driven and outputs sampled on
// the falling clock edge.
module tb_dm_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_a, wr_a, ready_a, err_a;
  logic [15:0] addr_a, wdata_a, rdata_a;
  logic        rd_b, wr_b, ready_b, err_b;
  logic [15:0] addr_b, wdata_b, rdata_b;

  always #5 clk = ~clk;

  dm_responder #(.ADDR_BITS(8), .WAIT_CYCLES(2)) dut_a (
    .Clk(clk), .Reset(rst_n), .DMRead(rd_a), .DMWrite(wr_a), .Addr(addr_a),
    .WriteData(wdata_a), .ReadData(rdata_a), .DMReady(ready_a), .DMErr(err_a)
  );

  dm_responder #(.ADDR_BITS(8), .WAIT_CYCLES(0)) dut_b (
    .Clk(clk), .Reset(rst_n), .DMRead(rd_b), .DMWrite(wr_b), .Addr(addr_b),
    .WriteData(wdata_b), .ReadData(rdata_b), .DMReady(ready_b), .DMErr(err_b)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] ref_mem [256];
  logic [15:0] ref_rdata;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        err;
    logic [15:0] rdata;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [15:0] d);
    if (sel == 0) begin
      rd_a = rd; wr_a = wr; addr_a = a; wdata_a = d;
    end else begin
      rd_b = rd; wr_b = wr; addr_b = a; wdata_b = d;
    end
  endtask

  // One transaction; lat is the number of falling edges from strobe to
  // DMReady, or -1 if DMReady never came within the budget.
  task automatic txn(input int sel, input logic rd, input logic wr,
                     input logic [15:0] a, input logic [15:0] d,
                     output int lat, output logic err, output logic [15:0] rdata);
    @(negedge clk);
    drive(sel, rd, wr, a, d);
    lat = -1; err = 1'b0; rdata = 16'h0000;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if ((sel == 0) ? ready_a : ready_b) begin
        lat   = n;
        err   = (sel == 0) ? err_a : err_b;
        rdata = (sel == 0) ? rdata_a : rdata_b;
        break;
      end
    end
    drive(sel, 1'b0, 1'b0, a, d);
  endtask

  // Reference: rejection = both strobes or address beyond 256 words; a good
  // read returns the stored word, a good write stores; latency is 3 edges.
  task automatic ref_txn(input string name, input logic rd, input logic wr,
                         input logic [15:0] a, input logic [15:0] d);
    int          lat;
    logic        err, exp_err;
    logic [15:0] rdata;
    exp_err = (rd && wr) || (a >= 16'd256);
    txn(0, rd, wr, a, d, lat, err, rdata);
    if (!exp_err && rd) ref_rdata = ref_mem[a[7:0]];
    if (!exp_err && wr) ref_mem[a[7:0]] = d;
    check({name, "_lat"}, 32'(lat), 32'd3);
    check({name, "_err"}, {31'd0, err}, {31'd0, exp_err});
    check({name, "_rdata"}, {16'd0, rdata}, {16'd0, ref_rdata});
  endtask

  initial begin
    int          lat;
    logic        err;
    logic [15:0] rdata;
    int          pulses, first_at, second_at;
    logic        saw_ready;
    logic [15:0] old2;

    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    ref_rdata = 16'h0000;

    // Reset state and quiet idle
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, ready_a}, 32'd0);
    check("rst_err", {31'd0, err_a}, 32'd0);
    check("rst_rdata", {16'd0, rdata_a}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_ready", {31'd0, ready_a}, 32'd0);
    end

    // Prefill every word so the reference knows the whole RAM
    for (int i = 0; i < 256; i++) ref_txn("fill", 1'b0, 1'b1, 16'(i), 16'($urandom));

    // Directed table
    vecs[0] = '{1'b0, 1'b1, 16'h0005, 16'hBEEF, 1'b0, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 16'hBEEF};
    vecs[2] = '{1'b1, 1'b0, 16'h0100, 16'h0000, 1'b1, 16'hBEEF};
    vecs[3] = '{1'b0, 1'b1, 16'h00FF, 16'h1357, 1'b0, 16'hBEEF};
    vecs[4] = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 1'b0, 16'h1357};
    vecs[5] = '{1'b0, 1'b1, 16'h0003, 16'h0AAA, 1'b0, 16'h1357};
    vecs[6] = '{1'b1, 1'b1, 16'h0003, 16'h1234, 1'b1, 16'h1357};
    vecs[7] = '{1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 16'h0AAA};
    vecs[8] = '{1'b0, 1'b1, 16'hFFFF, 16'h4444, 1'b1, 16'h0AAA};
    vecs[9] = '{1'b0, 1'b1, 16'h0100, 16'h5555, 1'b1, 16'h0AAA};
    for (int i = 0; i < 10; i++) begin
      txn(0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, err, rdata);
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd3);
      check($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].err});
      check($sformatf("vec%0d_rdata", i), {16'd0, rdata}, {16'd0, vecs[i].rdata});
      @(negedge clk);
      check($sformatf("vec%0d_hold", i), {16'd0, rdata_a}, {16'd0, vecs[i].rdata});
      check($sformatf("vec%0d_pulse", i), {31'd0, ready_a}, 32'd0);
      if (!vecs[i].err && vecs[i].wr) ref_mem[vecs[i].addr[7:0]] = vecs[i].wdata;
      ref_rdata = vecs[i].rdata;
    end

    // Addr/data/strobe changes after capture are ignored
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 16'h0007, 16'h00AA);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 16'h0009, 16'hFFFF);
    lat = -1;
    for (int n = 2; n <= 20; n++) begin
      @(negedge clk);
      if (ready_a) begin lat = n; break; end
    end
    check("late_change_lat", 32'(lat), 32'd3);
    ref_mem[7] = 16'h00AA;
    ref_txn("read7", 1'b1, 1'b0, 16'h0007, 16'h0);
    ref_txn("read9", 1'b1, 1'b0, 16'h0009, 16'h0);

    // Held DMRead gives back-to-back pulses four cycles apart
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 16'h000A, 16'h0);
    pulses = 0; first_at = 0; second_at = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (ready_a) begin
        pulses++;
        if (pulses == 1) first_at = n; else second_at = n;
      end
      if (n == 7) drive(0, 1'b0, 1'b0, 16'h000A, 16'h0);
    end
    ref_rdata = ref_mem[10];
    check("b2b_pulses", 32'(pulses), 32'd2);
    check("b2b_first", 32'(first_at), 32'd3);
    check("b2b_spacing", 32'(second_at - first_at), 32'd4);
    check("b2b_rdata", {16'd0, rdata_a}, {16'd0, ref_rdata});

    // Reset during WAIT discards a pending write
    old2 = ref_mem[2];
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 16'h0002, 16'h5555);
    @(negedge clk);
    rst_n = 1'b0;
    saw_ready = 1'b0;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      saw_ready |= ready_a;
    end
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    rst_n = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      saw_ready |= ready_a;
    end
    check("rstmid_no_ready", {31'd0, saw_ready}, 32'd0);
    check("rstmid_rdata", {16'd0, rdata_a}, 32'd0);
    ref_rdata = 16'h0000;
    ref_txn("rstmid_read2", 1'b1, 1'b0, 16'h0002, 16'h0);
    check("rstmid_ram2", {16'd0, ref_rdata}, {16'd0, old2});

    // Randomized traffic against the reference
    for (int i = 0; i < 200; i++) begin
      logic        rd, wr;
      logic [15:0] a;
      int          k;
      k = $urandom_range(0, 7);
      rd = (k < 4) || (k == 7);
      wr = (k >= 4);
      case ($urandom_range(0, 5))
        0:       a = 16'h00FF;
        1:       a = 16'h0100;
        2:       a = 16'($urandom_range(256, 65535));
        default: a = 16'($urandom_range(0, 255));
      endcase
      ref_txn("rand", rd, wr, a, 16'($urandom));
    end

    // Zero wait states: DMReady one cycle after capture
    txn(1, 1'b0, 1'b1, 16'h0020, 16'h1111, lat, err, rdata);
    check("w0_wr_lat", 32'(lat), 32'd1);
    check("w0_wr_err", {31'd0, err}, 32'd0);
    txn(1, 1'b1, 1'b0, 16'h0020, 16'h0, lat, err, rdata);
    check("w0_rd_lat", 32'(lat), 32'd1);
    check("w0_rd_data", {16'd0, rdata}, 32'h1111);
    txn(1, 1'b1, 1'b0, 16'h0100, 16'h0, lat, err, rdata);
    check("w0_oor_lat", 32'(lat), 32'd1);
    check("w0_oor_err", {31'd0, err}, 32'd1);
    check("w0_oor_data", {16'd0, rdata}, 32'h1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
